booth_mult_seq: RTL
===================

# booth_mult_seq

Parametrised sequential radix-4 (modified Booth) multiplier for the MultDiv unit, the successor to the fixed 32-bit multiplier. Generalises operand width, adds a signed/unsigned mode, a start/busy/done handshake, and an optional result-overflow flag. Sits beside the divider behind the ALU's multi-cycle operation dispatch; the pipeline stalls on `busy` and captures `result` on `done`.

## Interface
- `WIDTH`, default 32: operand width in bits; must be even and ≥ 4.
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `multiplicand`  in  WIDTH  operand A; sampled with `start`.
- `multiplier`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  single-cycle pulse; `product`/`result` valid from this cycle.
- `product`  out  2*WIDTH  full product.
- `result`  out  WIDTH  low WIDTH bits of `product`.
- `overflow`  out  1  product not representable in WIDTH bits for the selected mode (see Configuration).

## Operation
- Operands extend internally to N = WIDTH+2 bits: sign-extend when `is_signed`=1, zero-extend otherwise, so one datapath covers both modes.
- Accumulator register of 2N+1 bits: {upper N, multiplier N, guard bit 0}. Upper half cleared at load.
- Each RUN cycle: decode acc[2:0] → {0, +A, +A, +2A, −2A, −A, −A, 0} for 000…111; add to upper N+1 bits (with one sign-extension bit); arithmetic-shift the whole register right by 2.
- Iterations: N/2 = WIDTH/2+1. Iteration counter is internal; it loads at accept and decrements.
- States: IDLE → (start) RUN → (counter reaches 0) DONE → IDLE. No other transitions, except reset.
- `product` = low 2*WIDTH bits of the final accumulator, excluding the guard bit. It is registered in DONE and held until the next accepted `start` completes.
- `start` during RUN or DONE is ignored; no queueing.
- Zero operands run the full iteration count; there is no early termination.

## Timing
- Accepting edge = edge E with IDLE and `start`=1.
- `busy`=1 from E+1. RUN occupies WIDTH/2+1 cycles. DONE is the next cycle: `done`=1 and `busy`=1. IDLE follows, and a new `start` can be accepted on the edge that leaves DONE+1.
- Latency from `start` to `done` is WIDTH/2+2 cycles; for WIDTH=32 it is 18.
- Reset (asynchronous assert, any state): state=IDLE, `busy`=0, `done`=0, `product`=0, `result`=0, `overflow`=0, accumulator and counter cleared. An operation in flight is discarded.
- After reset deassertion, the first edge may accept `start`.

## Configuration
- `BOOTH_MULT_OVF_EN` defined: `overflow` is computed in DONE and registered with `product`.
  - Signed mode: set if the upper WIDTH+1 bits of `product` are not all equal.
  - Unsigned mode: set if the upper WIDTH bits are non-zero.
- Undefined: `overflow` is tied to 0 and the detection logic is absent.

## Structure
- Shared package `multdiv_pkg`:
  - Booth-digit encoding typedef (ZERO, POS1, POS2, NEG1, NEG2).
  - FSM state typedef (IDLE, RUN, DONE).
  - Width-check constant helpers.
- One sub-module, `booth_r4_step`: combinational. Takes the 3-bit window and the extended multiplicand; produces the N+1-bit partial-product addend and the carry-in. This keeps the top level to FSM, counter and registers.

## Test plan
- WIDTH=32, signed, 7 × −3 → after 18 cycles `done` pulses; `product`=0xFFFFFFFF_FFFFFFEB, `result`=0xFFFFFFEB, `overflow`=0.
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF → `product`=0xFFFFFFFE_00000001, `overflow`=1 with macro, 0 without.
- WIDTH=32, signed, 0x80000000 × 0xFFFFFFFF → `product`=0x00000000_80000000, `result`=0x80000000, `overflow`=1 (with macro).
- WIDTH=8, exhaustive sweep over all 65536 pairs in both modes → every `product` matches the reference model; `done` arrives exactly 6 cycles after `start`.
- `start` pulsed again mid-RUN with different operands → ignored; first result unchanged; exactly one `done`.
- `rst_n` asserted at RUN cycle 5 → all outputs 0 immediately; after release, a new 3 × 5 unsigned produces 15 with normal latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and width helpers for the MultDiv unit.
package multdiv_pkg;

   // Radix-4 Booth digit selected by one 3-bit multiplier window
   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_e;

   // Sequencer states for the multi-cycle multiplier
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mult_state_e;

   // Operand width must be even (whole radix-4 digits) and at least 4
   function automatic bit width_ok(input int w);
      return (w >= 4) && ((w % 2) == 0);
   endfunction

   // Internal operand width: two extra bits so unsigned operands stay positive
   // and +/-2A never overflows the extended datapath
   function automatic int ext_width(input int w);
      return w + 2;
   endfunction

   // Number of radix-4 iterations over the extended multiplier
   function automatic int iter_count(input int w);
      return (w + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_step.sv
// Combinational radix-4 Booth step: turns one 3-bit multiplier window into
// the (N+1)-bit addend for the accumulator's upper half plus its carry-in.
// Negative digits are returned as the one's complement with carry_in=1.
module booth_r4_step
   import multdiv_pkg::*;
#(
   parameter int N = 34
) (
   input  logic [2:0] window,
   input  logic [N-1:0] a_ext,
   output logic [N:0] addend,
   output logic carry_in
);

   booth_digit_e digit;
   logic [N:0] a_x1;
   logic [N:0] a_x2;

   // A is already sign-extended by two bits, so 2A fits in N+1 bits
   assign a_x1 = {a_ext[N-1], a_ext};
   assign a_x2 = {a_ext, 1'b0};

   // Window-to-digit recoding
   always_comb begin
      digit = ZERO;
      case (window)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
   end

   // Digit-to-addend selection; subtraction via invert plus carry-in
   always_comb begin
      addend   = '0;
      carry_in = 1'b0;
      case (digit)
         POS1: addend = a_x1;
         POS2: addend = a_x2;
         NEG1: begin
            addend   = ~a_x1;
            carry_in = 1'b1;
         end
         NEG2: begin
            addend   = ~a_x2;
            carry_in = 1'b1;
         end
         default: addend = '0;
      endcase
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, WIDTH/2+1 RUN
// cycles per product with start/busy/done handshake.
// Optional feature: define BOOTH_MULT_OVF_EN to compute the overflow flag;
// otherwise overflow is tied low.
module booth_mult_seq
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   result,
   output logic               overflow
);

   localparam int N     = ext_width(WIDTH);
   localparam int ITERS = iter_count(WIDTH);
   localparam int CNT_W = $clog2(ITERS + 1);
   localparam int ACC_W = 2 * N + 1;

   mult_state_e state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg;
   logic [N-1:0]       a_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2*WIDTH-1:0] product_reg;

   logic             accept;
   logic             last_step;
   logic [N-1:0]     a_ext_in;
   logic [N-1:0]     b_ext_in;
   logic [N:0]       upper_ext;
   logic [N:0]       addend;
   logic             carry_in;
   logic [N:0]       sum;
   logic [ACC_W-1:0] acc_step;
   logic [2*WIDTH-1:0] product_next;

   assign accept    = (state_reg == IDLE) && start;
   assign last_step = (state_reg == RUN) && (cnt_reg == CNT_W'(1));

   // One datapath serves both modes: sign- or zero-extend to N bits
   assign a_ext_in = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
   assign b_ext_in = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                               : {2'b00, multiplier};

   booth_r4_step #(
      .N (N)
   ) u_step (
      .window   (acc_reg[2:0]),
      .a_ext    (a_reg),
      .addend   (addend),
      .carry_in (carry_in)
   );

   // Add into the sign-extended upper half, then arithmetic shift right by 2
   assign upper_ext    = {acc_reg[ACC_W-1], acc_reg[ACC_W-1:N+1]};
   assign sum          = upper_ext + addend + {{N{1'b0}}, carry_in};
   assign acc_step     = {sum[N], sum, acc_reg[N:2]};
   assign product_next = acc_step[2*WIDTH:1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: start is only honoured in IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt_reg == CNT_W'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         RUN:  busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Accumulator, multiplicand and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         a_reg   <= '0;
         cnt_reg <= '0;
      end else if (accept) begin
         acc_reg <= {{N{1'b0}}, b_ext_in, 1'b0};
         a_reg   <= a_ext_in;
         cnt_reg <= CNT_W'(ITERS);
      end else if (state_reg == RUN) begin
         acc_reg <= acc_step;
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   // Product captured on the final step so it is valid in the DONE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         product_reg <= '0;
      else if (last_step) product_reg <= product_next;
   end

   assign product = product_reg;
   assign result  = product_reg[WIDTH-1:0];

`ifdef BOOTH_MULT_OVF_EN
   logic signed_reg;
   logic overflow_reg;
   logic overflow_next;
   logic [WIDTH:0]   upper_s;
   logic [WIDTH-1:0] upper_u;

   assign upper_s = product_next[2*WIDTH-1:WIDTH-1];
   assign upper_u = product_next[2*WIDTH-1:WIDTH];
   assign overflow_next = signed_reg ? !((&upper_s) || !(|upper_s))
                                     : (|upper_u);

   // Remember the operand mode for overflow detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      signed_reg <= 1'b0;
      else if (accept) signed_reg <= is_signed;
   end

   // Overflow registered alongside the product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         overflow_reg <= 1'b0;
      else if (last_step) overflow_reg <= overflow_next;
   end

   assign overflow = overflow_reg;
`else
   assign overflow = 1'b0;
`endif

endmodule
